// File: rtl/reg_write_queue.sv
// reg_write_queue
//   Commit write-back buffer between the reorder-buffer commit stage and the
//   register file's single write port. Accepts up to two retired results per
//   cycle (slot 0 older than slot 1) and drains them in program order, one per
//   cycle. Two bypass lookup ports expose committed-but-unwritten values.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global pause when low)
//   c0_valid/c0_rd/c0_val, c1_valid/c1_rd/c1_val : commit slots
//   c_ready            : both commit slots may be presented this cycle
//   set_reg_id/set_val : register file write port (id 0 = no write)
//   q_id1/q_id2 -> q_hit1/q_val1, q_hit2/q_val2 : bypass lookups
//   empty              : no pending entries
module reg_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        c0_valid,
  input  logic [4:0]  c0_rd,
  input  logic [31:0] c0_val,
  input  logic        c1_valid,
  input  logic [4:0]  c1_rd,
  input  logic [31:0] c1_val,
  output logic        c_ready,
  output logic [4:0]  set_reg_id,
  output logic [31:0] set_val,
  input  logic [4:0]  q_id1,
  input  logic [4:0]  q_id2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic [31:0] q_val1,
  output logic [31:0] q_val2,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_q  [DEPTH];
  logic [31:0]   val_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push0, push1, pop;
  logic [PW-1:0] wr_idx1;

  // Needs two free slots regardless of how many slots are actually valid;
  // a pop in the same cycle gives no credit. Held low while in reset.
  assign c_ready = rst_in && rdy_in && (count_q <= CW'(DEPTH - 2));

  assign push0 = c_ready && c0_valid && (c0_rd != 5'd0);
  assign push1 = c_ready && c1_valid && (c1_rd != 5'd0);
  assign pop   = rdy_in && (count_q != '0);

  // A dropped slot 0 consumes no entry, so slot 1 lands at tail in that case.
  assign wr_idx1 = tail_q + PW'(push0);

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push0) + PW'(push1);
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else begin
      if (push0) begin
        rd_q[tail_q]  <= c0_rd;
        val_q[tail_q] <= c0_val;
      end
      if (push1) begin
        rd_q[wr_idx1]  <= c1_rd;
        val_q[wr_idx1] <= c1_val;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign set_reg_id = pop ? rd_q[head_q]  : 5'd0;
  assign set_val    = pop ? val_q[head_q] : 32'd0;
  assign empty      = (count_q == '0);

  // Walk pending entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    q_hit1 = 1'b0;
    q_val1 = 32'd0;
    q_hit2 = 1'b0;
    q_val2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((q_id1 != 5'd0) && (rd_q[idx] == q_id1)) begin
          q_hit1 = 1'b1;
          q_val1 = val_q[idx];
        end
        if ((q_id2 != 5'd0) && (rd_q[idx] == q_id2)) begin
          q_hit2 = 1'b1;
          q_val2 = val_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
// Testbench for reg_write_queue: stimulus side pushes expected pending
// writes into a reference queue; a negedge monitor compares every output.
module tb_reg_write_queue;

  localparam int DEPTH = 4;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        c0_valid, c1_valid;
  logic [4:0]  c0_rd, c1_rd;
  logic [31:0] c0_val, c1_val;
  logic        c_ready;
  logic [4:0]  set_reg_id;
  logic [31:0] set_val;
  logic [4:0]  q_id1, q_id2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_val1, q_val2;
  logic        empty;

  reg_write_queue #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .c0_valid(c0_valid), .c0_rd(c0_rd), .c0_val(c0_val),
    .c1_valid(c1_valid), .c1_rd(c1_rd), .c1_val(c1_val),
    .c_ready(c_ready), .set_reg_id(set_reg_id), .set_val(set_val),
    .q_id1(q_id1), .q_id2(q_id2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_val1(q_val1), .q_val2(q_val2),
    .empty(empty)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  // Pending writes in program order; front is the next register-file write.
  ent_t exp_q[$];
  logic exp_cready = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle of stimulus. Inputs change 1 time unit after posedge;
  // accepted entries join the reference queue just before the next posedge.
  task automatic cyc(input logic rdy, input logic rst,
                     input logic v0, input logic [4:0] rd0, input logic [31:0] val0,
                     input logic v1, input logic [4:0] rd1, input logic [31:0] val1,
                     input logic [4:0] id1, input logic [4:0] id2);
    logic acc;
    @(posedge clk_in);
    #1;
    rdy_in = rdy; rst_in = rst;
    c0_valid = v0; c0_rd = rd0; c0_val = val0;
    c1_valid = v1; c1_rd = rd1; c1_val = val1;
    q_id1 = id1; q_id2 = id2;
    if (!rst) exp_q.delete();
    acc = rst && rdy && ((DEPTH - exp_q.size()) >= 2);
    exp_cready = acc;
    #6;
    if (acc && v0 && rd0 != 5'd0) exp_q.push_back({rd0, val0});
    if (acc && v1 && rd1 != 5'd0) exp_q.push_back({rd1, val1});
  endtask

  task automatic idle(input logic rdy, input logic [4:0] id1, input logic [4:0] id2);
    cyc(rdy, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, id1, id2);
  endtask

  always @(negedge clk_in) begin : monitor
    logic        eh1, eh2;
    logic [31:0] ev1, ev2;
    eh1 = 1'b0; eh2 = 1'b0; ev1 = 32'd0; ev2 = 32'd0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (q_id1 != 5'd0 && exp_q[i].rd == q_id1) begin eh1 = 1'b1; ev1 = exp_q[i].val; end
      if (q_id2 != 5'd0 && exp_q[i].rd == q_id2) begin eh2 = 1'b1; ev2 = exp_q[i].val; end
    end
    chk("c_ready", 32'(c_ready), 32'(exp_cready));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("q_hit1", 32'(q_hit1), 32'(eh1));
    chk("q_val1", q_val1, ev1);
    chk("q_hit2", 32'(q_hit2), 32'(eh2));
    chk("q_val2", q_val2, ev2);
    if (rst_in && rdy_in && exp_q.size() > 0) begin
      chk("set_reg_id", 32'(set_reg_id), 32'(exp_q[0].rd));
      chk("set_val", set_val, exp_q[0].val);
      void'(exp_q.pop_front());
    end else begin
      chk("set_reg_id_idle", 32'(set_reg_id), 32'd0);
      chk("set_val_idle", set_val, 32'd0);
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    c0_valid = 1'b0; c0_rd = '0; c0_val = '0;
    c1_valid = 1'b0; c1_rd = '0; c1_val = '0;
    q_id1 = '0; q_id2 = '0;

    // reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle(1, 0, 0);

    // single commit
    cyc(1, 1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 0);
    idle(1, 5'd5, 0);
    idle(1, 5'd5, 0);

    // dual commit, same rd
    cyc(1, 1, 1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 5'd7, 0);
    idle(1, 5'd7, 5'd7);
    idle(1, 5'd7, 0);
    idle(1, 0, 0);

    // x0 filtering
    cyc(1, 1, 1, 5'd0, 32'h55, 1, 5'd3, 32'd9, 5'd3, 0);
    idle(1, 5'd0, 5'd3);
    idle(1, 0, 0);

    // back-pressure and pointer wrap
    for (int k = 0; k < 5; k++)
      cyc(1, 1, 1, 5'(8 + 2*k), 32'(100 + 2*k), 1, 5'(9 + 2*k), 32'(101 + 2*k), 5'(9 + 2*k), 5'd8);
    repeat (6) idle(1, 5'd10, 5'd12);

    // pause with entries pending, then reset mid-flight
    cyc(1, 1, 1, 5'd20, 32'hA0, 1, 5'd21, 32'hA1, 0, 0);
    cyc(1, 1, 1, 5'd22, 32'hA2, 1, 5'd23, 32'hA3, 0, 0);
    repeat (4) idle(0, 5'd21, 5'd23);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 5'd22, 5'd23);
    idle(1, 5'd22, 0);
    idle(1, 0, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (8) idle(1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
